// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter - shares one synchronous data RAM between the CPU MEM stage and an EXT port
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic              ext_lock_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_gnt_o,
    output logic              ext_rvalid_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] C_STARVE_LIM  = SW'(STARVE_LIM);
    localparam logic [SW-1:0] C_STARVE_LAST = SW'(STARVE_LIM - 1);
    localparam logic [LW-1:0] C_LOCK_MAX    = LW'(LOCK_MAX);

    typedef enum logic [1:0] {
        CPU_PRIO  = 2'd0,
        EXT_FORCE = 2'd1,
        EXT_LOCK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_ext_q, rd_ext_d;
    logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

    logic cpu_sel, ext_sel;
    logic cpu_gnt, ext_gnt;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cpu_sel    = 1'b0;
        ext_sel    = 1'b0;
        case (state_q)
            CPU_PRIO: begin
                cpu_sel = cpu_req_i;
                ext_sel = ~cpu_req_i & ext_req_i;
                if (ext_sel && ext_lock_i) begin
                    state_d    = EXT_LOCK;
                    lock_cnt_d = LW'(1);
                end else if (cpu_req_i && ext_req_i && (starve_cnt_q >= C_STARVE_LAST)) begin
                    state_d = EXT_FORCE;
                end
            end
            EXT_FORCE: begin
                if (ext_req_i) begin
                    ext_sel    = 1'b1;
                    state_d    = ext_lock_i ? EXT_LOCK : CPU_PRIO;
                    lock_cnt_d = ext_lock_i ? LW'(1) : LW'(0);
                end else begin
                    cpu_sel = cpu_req_i;
                    state_d = CPU_PRIO;
                end
            end
            EXT_LOCK: begin
                if (!ext_req_i || !ext_lock_i) begin
                    // Burst ended: this cycle already arbitrates with CPU priority.
                    cpu_sel    = cpu_req_i;
                    ext_sel    = ~cpu_req_i & ext_req_i;
                    state_d    = CPU_PRIO;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == C_LOCK_MAX) begin
                    cpu_sel    = cpu_req_i;
                    lock_cnt_d = '0;
                end else begin
                    ext_sel    = 1'b1;
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d    = CPU_PRIO;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign cpu_gnt = rst_ni & cpu_sel;
    assign ext_gnt = rst_ni & ext_sel;

    always_comb begin
        starve_cnt_d = '0;
        if (ext_req_i && !ext_gnt) begin
            starve_cnt_d = (starve_cnt_q == C_STARVE_LIM) ? starve_cnt_q
                                                          : starve_cnt_q + SW'(1);
        end
    end

    assign rd_pend_d = (cpu_gnt & ~cpu_we_i) | (ext_gnt & ~ext_we_i);
    assign rd_ext_d  = ext_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= CPU_PRIO;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_ext_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_ext_q     <= rd_ext_d;
            if (cpu_rvalid_o) begin
                cpu_rdata_q <= mem_rdata_i;
            end
            if (ext_rvalid_o) begin
                ext_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign cpu_stall_o  = rst_ni & cpu_req_i & ~cpu_gnt;
    assign ext_gnt_o    = ext_gnt;
    assign cpu_rvalid_o = rd_pend_q & ~rd_ext_q;
    assign ext_rvalid_o = rd_pend_q & rd_ext_q;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
    assign ext_rdata_o  = ext_rvalid_o ? mem_rdata_i : ext_rdata_q;

    assign mem_en_o    = cpu_gnt | ext_gnt;
    assign mem_we_o    = (cpu_gnt & cpu_we_i) | (ext_gnt & ext_we_i);
    assign mem_addr_o  = ext_gnt ? ext_addr_i  : (cpu_gnt ? cpu_addr_i  : '0);
    assign mem_wdata_o = ext_gnt ? ext_wdata_i : (cpu_gnt ? cpu_wdata_i : '0);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter - directed self-checking bench for dmem_arbiter with a sync RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_we;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ram [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIM(8), .LOCK_MAX(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_lock_i(ext_lock), .ext_addr_i(ext_addr),
        .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
        .ext_rdata_o(ext_rdata), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = 0; ext_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[32'h40 >> 2]  = 32'h0000CAFE;
        ram[32'h100 >> 2] = 32'h00001234;
        ram[32'h104 >> 2] = 32'h00005678;

        // Reset: outputs quiet even with a request present
        idle_inputs();
        rst_n = 1'b0;
        cpu_req = 1;
        #3;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: CPU load 0x40
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        #1;
        chk("t1_mem_en", 32'(mem_en), 1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_cpu_stall", 32'(cpu_stall), 0);
        @(negedge clk);
        cpu_req = 0;
        #1;
        chk("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("t1_cpu_rdata", cpu_rdata, 32'h0000CAFE);
        chk("t1_ext_rvalid", 32'(ext_rvalid), 0);

        // 2: starvation forcing after 8 CPU grants
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'hAAAA;
            ext_req = 1; ext_we = 1; ext_lock = 0; ext_addr = 32'h300; ext_wdata = 32'hBBBB;
            #1;
            chk($sformatf("t2_ext_gnt_c%0d", k), 32'(ext_gnt), (k == 9) ? 1 : 0);
            chk($sformatf("t2_cpu_stall_c%0d", k), 32'(cpu_stall), (k == 9) ? 1 : 0);
            chk($sformatf("t2_mem_addr_c%0d", k), mem_addr, (k == 9) ? 32'h300 : 32'h80);
        end
        @(negedge clk);
        idle_inputs();

        // 3: locked EXT burst of 20 writes against a waiting CPU load
        for (int k = 1; k <= 22; k++) begin
            logic exp_ext;
            @(negedge clk);
            cpu_req = (k >= 2); cpu_we = 0; cpu_addr = 32'h40;
            ext_req = (k <= 21); ext_lock = (k <= 21); ext_we = 1;
            ext_addr = 32'h200; ext_wdata = 32'(k);
            #1;
            exp_ext = (k <= 21) && (k != 17);
            chk($sformatf("t3_ext_gnt_c%0d", k), 32'(ext_gnt), 32'(exp_ext));
            chk($sformatf("t3_cpu_stall_c%0d", k), 32'(cpu_stall), 32'((k >= 2) && exp_ext));
            chk($sformatf("t3_mem_we_c%0d", k), 32'(mem_we), 32'(exp_ext));
            chk($sformatf("t3_mem_en_c%0d", k), 32'(mem_en), 1);
            if (k == 17) chk("t3_mem_addr_cpu", mem_addr, 32'h40);
            if (k == 18) begin
                chk("t3_cpu_rvalid", 32'(cpu_rvalid), 1);
                chk("t3_cpu_rdata", cpu_rdata, 32'h0000CAFE);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("t3_cpu_rvalid_end", 32'(cpu_rvalid), 1);

        // 4: EXT read then CPU read back-to-back
        @(negedge clk);
        ext_req = 1; ext_we = 0; ext_addr = 32'h100;
        #1;
        chk("t4_ext_gnt", 32'(ext_gnt), 1);
        @(negedge clk);
        ext_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
        #1;
        chk("t4_ext_rvalid", 32'(ext_rvalid), 1);
        chk("t4_ext_rdata", ext_rdata, 32'h00001234);
        chk("t4_cpu_rvalid_c1", 32'(cpu_rvalid), 0);
        chk("t4_cpu_stall", 32'(cpu_stall), 0);
        @(negedge clk);
        cpu_req = 0;
        #1;
        chk("t4_cpu_rvalid_c2", 32'(cpu_rvalid), 1);
        chk("t4_cpu_rdata", cpu_rdata, 32'h00005678);
        chk("t4_ext_rvalid_c2", 32'(ext_rvalid), 0);
        chk("t4_ext_rdata_hold", ext_rdata, 32'h00001234);

        // 5: reset during EXT_LOCK with an EXT read in flight
        @(negedge clk);
        ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 32'h100;
        #1;
        chk("t5_lock_gnt", 32'(ext_gnt), 1);
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
        #1;
        chk("t5_ext_gnt", 32'(ext_gnt), 1);
        chk("t5_cpu_stall", 32'(cpu_stall), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_en", 32'(mem_en), 0);
        chk("t5_rst_ext_gnt", 32'(ext_gnt), 0);
        chk("t5_rst_cpu_stall", 32'(cpu_stall), 0);
        chk("t5_rst_ext_rvalid", 32'(ext_rvalid), 0);
        chk("t5_rst_ext_rdata", ext_rdata, 0);
        chk("t5_rst_cpu_rdata", cpu_rdata, 0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 32'h100;
        #1;
        chk("t5_post_ext_rvalid", 32'(ext_rvalid), 0);
        chk("t5_post_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("t5_post_cpu_stall", 32'(cpu_stall), 0);
        chk("t5_post_ext_gnt", 32'(ext_gnt), 0);

        // 6: idle
        @(negedge clk);
        idle_inputs();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t6_mem_en_c%0d", k), 32'(mem_en), 0);
            chk($sformatf("t6_cpu_stall_c%0d", k), 32'(cpu_stall), 0);
            chk($sformatf("t6_ext_gnt_c%0d", k), 32'(ext_gnt), 0);
        end
        chk("t6_starve_cnt", 32'(dut.starve_cnt_q), 0);
        chk("t6_lock_cnt", 32'(dut.lock_cnt_q), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
